branch_resolve_unit: RTL and testbench

Direct downstream consumer of the comparator's zf/cf flags. Captures the flags into an architectural flag register on each compare. Resolves conditional and unconditional branches against those flags and owns the program counter. Drives PC redirect and a one-cycle pipeline flush to fetch/decode.

---
 rtl/branch_pkg.sv | 25 ++
 rtl/branch_cond_eval.sv | 30 +++
 rtl/branch_resolve_unit.sv | 171 +++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// ============================================================================
// Module   : branch_pkg
// Purpose  : Shared encodings and types for the branch resolve unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package branch_pkg;

   localparam int DEFAULT_ADDR_W = 16;

   localparam logic [1:0] BR_JMP = 2'b00;
   localparam logic [1:0] BR_JE  = 2'b01;
   localparam logic [1:0] BR_JB  = 2'b10;
   localparam logic [1:0] BR_JA  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_WAIT_FLAGS = 2'd1,
      ST_REDIRECT   = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/branch_cond_eval.sv
// ============================================================================
// Module   : branch_cond_eval
// Purpose  : Combinational branch condition evaluation against zf/cf.
// Revision : 1.0
// ============================================================================
`default_nettype none

module branch_cond_eval
   import branch_pkg::*;
(
   input  logic [1:0] br_type,
   input  logic       zf,
   input  logic       cf,
   output logic       take
);

   always_comb begin
      take = 1'b0;
      case (br_type)
         BR_JMP:  take = 1'b1;
         BR_JE:   take = zf;
         BR_JB:   take = cf;
         BR_JA:   take = ~zf & ~cf;
         default: take = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/branch_resolve_unit.sv
// ============================================================================
// Module   : branch_resolve_unit
// Purpose  : Flag register, branch resolution, PC ownership, redirect/flush.
//            Optional BRANCH_STATS_EN adds saturating taken/not-taken counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module branch_resolve_unit
   import branch_pkg::*;
#(
   parameter int                ADDR_W   = DEFAULT_ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
)(
   input  logic              Clock,
   input  logic              Reset_n,
   input  logic              stall,
   input  logic              compare_valid,
   input  logic              zf_in,
   input  logic              cf_in,
   input  logic              branch_req,
   input  logic [1:0]        branch_type,
   input  logic [ADDR_W-1:0] branch_target,
   output logic [ADDR_W-1:0] pc,
   output logic              zf,
   output logic              cf,
   output logic              branch_taken,
   output logic              flush,
   output logic              busy
`ifdef BRANCH_STATS_EN
 , output logic [15:0]       taken_count
 , output logic [15:0]       not_taken_count
`endif
);

   localparam logic [ADDR_W-1:0] C_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t            r_state,    w_state_nxt;
   logic [ADDR_W-1:0] r_pc,       w_pc_nxt;
   logic [1:0]        r_lat_type, w_lat_type_nxt;
   logic [ADDR_W-1:0] r_lat_tgt,  w_lat_tgt_nxt;
   logic              r_redirect, w_redirect_nxt;
   logic              r_zf, r_cf, r_flags_valid;

   logic              w_eff_zf, w_eff_cf, w_take;
   logic [1:0]        w_eval_type;
   logic [ADDR_W-1:0] w_eval_tgt;
   logic              w_resolve, w_cond_res;

   // Fresh compare results bypass the flag register for same-cycle resolution.
   assign w_eff_zf    = compare_valid ? zf_in : r_zf;
   assign w_eff_cf    = compare_valid ? cf_in : r_cf;
   assign w_eval_type = (r_state == ST_WAIT_FLAGS) ? r_lat_type : branch_type;
   assign w_eval_tgt  = (r_state == ST_WAIT_FLAGS) ? r_lat_tgt  : branch_target;

   branch_cond_eval u_cond_eval (
      .br_type (w_eval_type),
      .zf      (w_eff_zf),
      .cf      (w_eff_cf),
      .take    (w_take)
   );

   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_lat_type_nxt = r_lat_type;
      w_lat_tgt_nxt  = r_lat_tgt;
      w_redirect_nxt = 1'b0;
      w_resolve      = 1'b0;
      w_cond_res     = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (!stall) begin
               if (!branch_req) begin
                  w_pc_nxt = r_pc + C_ONE;
               end else if (branch_type == BR_JMP) begin
                  w_resolve = 1'b1;
               end else if (r_flags_valid || compare_valid) begin
                  w_resolve  = 1'b1;
                  w_cond_res = 1'b1;
               end else begin
                  w_state_nxt    = ST_WAIT_FLAGS;
                  w_lat_type_nxt = branch_type;
                  w_lat_tgt_nxt  = branch_target;
               end
            end
         end
         ST_WAIT_FLAGS: begin
            if (compare_valid) begin
               w_resolve  = 1'b1;
               w_cond_res = 1'b1;
            end
         end
         ST_REDIRECT: w_state_nxt = ST_IDLE;
         default:     w_state_nxt = ST_IDLE;
      endcase

      if (w_resolve) begin
         if (w_take) begin
            w_pc_nxt       = w_eval_tgt;
            w_redirect_nxt = 1'b1;
            w_state_nxt    = ST_REDIRECT;
         end else begin
            w_pc_nxt    = r_pc + C_ONE;
            w_state_nxt = ST_IDLE;
         end
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state    <= ST_IDLE;
         r_pc       <= RESET_PC;
         r_lat_type <= BR_JMP;
         r_lat_tgt  <= {ADDR_W{1'b0}};
         r_redirect <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_lat_type <= w_lat_type_nxt;
         r_lat_tgt  <= w_lat_tgt_nxt;
         r_redirect <= w_redirect_nxt;
      end
   end

   // A compare in the consuming cycle refills the flags, so they stay valid.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_zf          <= 1'b0;
         r_cf          <= 1'b0;
         r_flags_valid <= 1'b0;
      end else if (compare_valid) begin
         r_zf          <= zf_in;
         r_cf          <= cf_in;
         r_flags_valid <= 1'b1;
      end else if (w_cond_res) begin
         r_flags_valid <= 1'b0;
      end
   end

`ifdef BRANCH_STATS_EN
   logic [15:0] r_taken_cnt, r_not_taken_cnt;

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_taken_cnt     <= 16'h0000;
         r_not_taken_cnt <= 16'h0000;
      end else if (w_cond_res) begin
         if (w_take) begin
            if (r_taken_cnt != 16'hFFFF) r_taken_cnt <= r_taken_cnt + 16'h0001;
         end else begin
            if (r_not_taken_cnt != 16'hFFFF) r_not_taken_cnt <= r_not_taken_cnt + 16'h0001;
         end
      end
   end

   assign taken_count     = r_taken_cnt;
   assign not_taken_count = r_not_taken_cnt;
`endif

   assign pc           = r_pc;
   assign zf           = r_zf;
   assign cf           = r_cf;
   assign branch_taken = r_redirect;
   assign flush        = r_redirect;
   assign busy         = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
// ============================================================================
// Module   : tb_branch_resolve_unit
// Purpose  : Directed self-checking bench for branch_resolve_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_branch_resolve_unit;

   logic        Clock = 1'b0;
   logic        Reset_n;
   logic        stall, compare_valid, zf_in, cf_in, branch_req;
   logic [1:0]  branch_type;
   logic [15:0] branch_target;
   logic [15:0] pc;
   logic        zf, cf, branch_taken, flush, busy;

   int vectors    = 0;
   int miscompares = 0;

   always #5 Clock = ~Clock;

   branch_resolve_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
      .Clock         (Clock),
      .Reset_n       (Reset_n),
      .stall         (stall),
      .compare_valid (compare_valid),
      .zf_in         (zf_in),
      .cf_in         (cf_in),
      .branch_req    (branch_req),
      .branch_type   (branch_type),
      .branch_target (branch_target),
      .pc            (pc),
      .zf            (zf),
      .cf            (cf),
      .branch_taken  (branch_taken),
      .flush         (flush),
      .busy          (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // pc, branch_taken, flush, busy in one go
   task automatic chk_all(input string tag, input logic [15:0] e_pc,
                          input logic e_tk, input logic e_fl, input logic e_bs);
      chk({tag, ".pc"},    {16'h0, pc},           {16'h0, e_pc});
      chk({tag, ".taken"}, {31'h0, branch_taken}, {31'h0, e_tk});
      chk({tag, ".flush"}, {31'h0, flush},        {31'h0, e_fl});
      chk({tag, ".busy"},  {31'h0, busy},         {31'h0, e_bs});
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic idle_inputs();
      stall = 0; compare_valid = 0; zf_in = 0; cf_in = 0;
      branch_req = 0; branch_type = 2'b00; branch_target = 16'h0000;
   endtask

   task automatic do_reset();
      @(negedge Clock);
      Reset_n = 0;
      #1;
      chk_all("rst", 16'h0000, 0, 0, 0);
      chk("rst.zf", {31'h0, zf}, 32'h0);
      chk("rst.cf", {31'h0, cf}, 32'h0);
      @(negedge Clock);
      Reset_n = 1;
   endtask

   initial begin
      Reset_n = 0;
      idle_inputs();
      #12;
      do_reset();

      // Free-running PC
      chk_all("idle0", 16'h0000, 0, 0, 0);
      for (int i = 1; i <= 4; i++) begin
         step();
         chk_all("idle", 16'(i), 0, 0, 0);
      end

      // Compare then JE taken
      compare_valid = 1; zf_in = 1; cf_in = 0;
      step();
      chk("cmp.zf", {31'h0, zf}, 32'h1);
      chk_all("cmp", 16'h0005, 0, 0, 0);
      idle_inputs();
      branch_req = 1; branch_type = 2'b01; branch_target = 16'h0040;
      step();
      chk_all("je_tk", 16'h0040, 1, 1, 1);
      idle_inputs();
      step();
      chk_all("je_redir", 16'h0040, 0, 0, 0);
      step();
      chk_all("je_after", 16'h0041, 0, 0, 0);

      // JB with no flags waits, ignores new requests while busy
      do_reset();
      idle_inputs();
      branch_req = 1; branch_type = 2'b10; branch_target = 16'h0200;
      step();
      chk_all("jb_wait0", 16'h0000, 0, 0, 1);
      branch_type = 2'b00; branch_target = 16'h0999; stall = 1;
      step();
      chk_all("jb_wait1", 16'h0000, 0, 0, 1);
      step();
      chk_all("jb_wait2", 16'h0000, 0, 0, 1);
      idle_inputs();
      compare_valid = 1; cf_in = 1;
      step();
      chk_all("jb_tk", 16'h0200, 1, 1, 1);
      chk("jb.cf", {31'h0, cf}, 32'h1);
      idle_inputs();
      step();
      chk_all("jb_redir", 16'h0200, 0, 0, 0);
      step();
      chk_all("jb_after", 16'h0201, 0, 0, 0);

      // Same-cycle bypass JA, flags stay valid; JE then not taken
      compare_valid = 1; zf_in = 0; cf_in = 0;
      branch_req = 1; branch_type = 2'b11; branch_target = 16'h0100;
      step();
      chk_all("ja_tk", 16'h0100, 1, 1, 1);
      chk("ja.cf", {31'h0, cf}, 32'h0);
      idle_inputs();
      step();
      chk_all("ja_redir", 16'h0100, 0, 0, 0);
      branch_req = 1; branch_type = 2'b01; branch_target = 16'h0777;
      step();
      chk_all("je_nt", 16'h0101, 0, 0, 0);

      // JMP needs no flags; wrap at top of address space
      branch_req = 1; branch_type = 2'b00; branch_target = 16'hFFFE;
      step();
      chk_all("jmp_tk", 16'hFFFE, 1, 1, 1);
      idle_inputs();
      step();
      chk_all("jmp_redir", 16'hFFFE, 0, 0, 0);
      step();
      chk_all("pre_wrap", 16'hFFFF, 0, 0, 0);
      step();
      chk_all("wrap", 16'h0000, 0, 0, 0);

      // Stall freezes pc and ignores requests
      stall = 1; branch_req = 1; branch_type = 2'b00; branch_target = 16'h1234;
      step();
      chk_all("stall", 16'h0000, 0, 0, 0);
      idle_inputs();
      step();
      chk_all("unstall", 16'h0001, 0, 0, 0);

      // Flags consumed by JE above: new JE must wait; async reset abandons it
      branch_req = 1; branch_type = 2'b01; branch_target = 16'h0300;
      step();
      chk_all("je_wait", 16'h0001, 0, 0, 1);
      idle_inputs();
      Reset_n = 0;
      #1;
      chk_all("async_rst", 16'h0000, 0, 0, 0);
      @(negedge Clock);
      Reset_n = 1;
      compare_valid = 1; zf_in = 1;
      step();
      chk_all("post_rst", 16'h0001, 0, 0, 0);
      idle_inputs();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
